led_breath_pwm: RTL and testbench

// - Output stage directly downstream of the led pattern generator: takes its 4-bit pattern and drives the board LED pins.
// - Pass-through, fixed-duty PWM dimming, or automatic "breathing" (triangle ramp of brightness).
// - Duty and mode are applied only on PWM period boundaries, so pins never see a runt pulse.

---
 rtl/led_pkg.sv | 8 +
 rtl/led_breath_pwm_if.sv | 11 +
 rtl/led_pwm_timebase.sv | 32 +++
 rtl/led_breath_pwm.sv | 58 +++++
 tb/tb_led_breath_pwm.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings and breathing state type for the LED output stage
package led_pkg;
  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_BREATH = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;
  typedef enum logic {UP, DOWN} breath_e;
endpackage

// File: rtl/led_breath_pwm_if.sv
// led_breath_pwm_if: pattern/mode/duty inputs and LED drive outputs of the LED output stage
interface led_breath_pwm_if #(parameter int PWM_BITS = 8);
  logic [3:0]          led_in;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty;
  logic [3:0]          pio_led;
  logic [PWM_BITS-1:0] level;
  logic                period_tick;
  modport master(output led_in, mode, duty, input pio_led, level, period_tick);
  modport slave(input led_in, mode, duty, output pio_led, level, period_tick);
endinterface

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: free-running PWM counter, end-of-period tick and breathing step strobe
module led_pwm_timebase #(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                period_tick_o,
  output logic                step_en_o
);
  localparam int SW = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                period_tick_q;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  assign step_en_o     = period_tick_q && step_cnt_q == STEP_LAST;
  assign step_cnt_d    = step_en_o ? '0 : step_cnt_q + SW'(period_tick_q);
  assign pwm_cnt_o     = pwm_cnt_q;
  assign period_tick_o = period_tick_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q     <= '0;
      period_tick_q <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_q + PWM_BITS'(1);
      period_tick_q <= &pwm_cnt_q;
      step_cnt_q    <= step_cnt_d;
    end
  end
endmodule

// File: rtl/led_breath_pwm.sv
// led_breath_pwm: LED pin driver with pass-through, fixed-duty PWM and triangle breathing
module led_breath_pwm import led_pkg::*; #(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 1024
) (
  input logic             clk,
  input logic             rst,
  led_breath_pwm_if.slave bus
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_tick, step_en, boundary;
  breath_e             state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d, act_duty_q, act_duty_d;
  logic [1:0]          act_mode_q, act_mode_d;
  logic [3:0]          pio_q, pio_d;
  led_pwm_timebase #(.PWM_BITS(PWM_BITS), .STEP_PERIODS(STEP_PERIODS)) u_tb (
    .clk(clk), .rst(rst), .pwm_cnt_o(pwm_cnt), .period_tick_o(period_tick), .step_en_o(step_en)
  );
  assign boundary = pwm_cnt == MAX;
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (step_en && act_mode_q == MODE_BREATH) begin
      if (state_q == UP) begin
        state_d = level_q == MAX ? DOWN : UP;
        level_d = level_q == MAX ? MAX - PWM_BITS'(1) : level_q + PWM_BITS'(1);
      end else begin
        state_d = level_q == '0 ? UP : DOWN;
        level_d = level_q == '0 ? PWM_BITS'(1) : level_q - PWM_BITS'(1);
      end
    end
  end
  // Mode and duty only change at the period boundary so the pins never see a runt pulse
  assign act_mode_d = boundary ? bus.mode : act_mode_q;
  assign act_duty_d = boundary && bus.mode == MODE_FIXED  ? bus.duty :
                      boundary && bus.mode == MODE_BREATH ? level_q  : act_duty_q;
  assign pio_d = act_mode_q == MODE_PASS ? bus.led_in :
                 act_mode_q == MODE_OFF  ? 4'b0000    : bus.led_in & {4{pwm_cnt < act_duty_q}};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UP;
      level_q    <= '0;
      act_mode_q <= MODE_PASS;
      act_duty_q <= '0;
      pio_q      <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      act_mode_q <= act_mode_d;
      act_duty_q <= act_duty_d;
      pio_q      <= pio_d;
    end
  end
  assign bus.pio_led     = pio_q;
  assign bus.level       = level_q;
  assign bus.period_tick = period_tick;
endmodule

// File: tb/tb_led_breath_pwm.sv
// tb_led_breath_pwm: table vectors, directed PWM/breathing sequences and randomized run vs a phase-based model
module tb_led_breath_pwm;
  import led_pkg::*;
  localparam int PB = 4;
  localparam int SP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;
  led_breath_pwm_if #(.PWM_BITS(PB)) bus();
  led_breath_pwm #(.PWM_BITS(PB), .STEP_PERIODS(SP)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int n, ticks, phase;
  logic [1:0] m_mode;
  logic [3:0] m_duty, m_pio;
  logic m_tick;
  typedef struct {
    logic       rst;
    logic [3:0] led;
    logic [1:0] mode;
    logic [3:0] duty;
    logic [3:0] pio;
    logic       tick;
  } vec_t;
  vec_t tbl [6];
  function automatic int tri_lvl(int p);
    int q = p % 30;
    return q <= 15 ? q : 30 - q;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic clk_step();
    int pwm;
    bit st;
    logic [1:0] old_mode;
    if (rst) begin
      n = 0; ticks = 0; phase = 0; m_mode = MODE_PASS; m_duty = 0; m_pio = 0; m_tick = 0;
    end else begin
      pwm = n % 16;
      st = 0;
      old_mode = m_mode;
      if (m_tick) begin
        ticks++;
        st = (ticks % SP) == 0;
      end
      m_pio = m_mode == MODE_PASS ? bus.led_in : m_mode == MODE_OFF ? 4'b0 :
              (pwm < int'(m_duty) ? bus.led_in : 4'b0);
      if (pwm == 15) begin
        if (bus.mode == MODE_FIXED) m_duty = bus.duty;
        else if (bus.mode == MODE_BREATH) m_duty = 4'(tri_lvl(phase));
        m_mode = bus.mode;
      end
      if (st && old_mode == MODE_BREATH) phase++;
      m_tick = pwm == 15;
      n++;
    end
    @(posedge clk);
    #1;
    check("model_pio_led", bus.pio_led, m_pio);
    check("model_level", bus.level, tri_lvl(phase));
    check("model_period_tick", bus.period_tick, m_tick);
  endtask
  task automatic align();
    for (int i = 0; i < 40; i++) begin
      clk_step();
      if (bus.period_tick) return;
    end
    check("align_timeout", 0, 1);
  endtask
  task automatic count_period(output int on, output logic [3:0] seen);
    on = 0;
    seen = 0;
    repeat (16) begin
      clk_step();
      if (bus.pio_led != 0) on++;
      seen |= bus.pio_led;
    end
  endtask
  initial begin
    int on, k, lat;
    logic [3:0] seen;
    bus.led_in = 0; bus.mode = MODE_PASS; bus.duty = 0;
    tbl[0] = '{1'b1, 4'b1010, MODE_PASS,  4'd0, 4'b0000, 1'b0};
    tbl[1] = '{1'b0, 4'b1010, MODE_PASS,  4'd0, 4'b1010, 1'b0};
    tbl[2] = '{1'b0, 4'b0101, MODE_PASS,  4'd0, 4'b0101, 1'b0};
    tbl[3] = '{1'b0, 4'b0101, MODE_FIXED, 4'd0, 4'b0101, 1'b0};
    tbl[4] = '{1'b0, 4'b1111, MODE_OFF,   4'd0, 4'b1111, 1'b0};
    tbl[5] = '{1'b0, 4'b0000, MODE_PASS,  4'd0, 4'b0000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; bus.led_in = tbl[i].led; bus.mode = tbl[i].mode; bus.duty = tbl[i].duty;
      clk_step();
      check("tbl_pio_led", bus.pio_led, tbl[i].pio);
      check("tbl_period_tick", bus.period_tick, tbl[i].tick);
    end
    rst = 1;
    repeat (5) clk_step();
    check("rst_pio_led", bus.pio_led, 0);
    check("rst_level", bus.level, 0);
    check("rst_period_tick", bus.period_tick, 0);
    rst = 0;
    k = 41;
    for (int i = 1; i <= 40; i++) begin
      clk_step();
      if (bus.period_tick) begin k = i; break; end
    end
    check("first_tick_latency", k, 16);
    bus.led_in = 4'b1111; bus.mode = MODE_FIXED; bus.duty = 4;
    align();
    count_period(on, seen);
    check("fixed_duty4_on", on, 4);
    bus.duty = 0;
    align();
    count_period(on, seen);
    check("fixed_duty0_on", on, 0);
    bus.duty = 4; bus.led_in = 4'b0011;
    align();
    count_period(on, seen);
    check("fixed_mask_on", on, 4);
    check("fixed_mask_pins", seen, 4'b0011);
    bus.led_in = 4'b1111;
    align();
    on = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) bus.duty = 12;
      clk_step();
      if (bus.pio_led != 0) on++;
    end
    check("midchg_cur_period", on, 4);
    count_period(on, seen);
    check("midchg_next_period", on, 12);
    on = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) bus.mode = MODE_OFF;
      clk_step();
      if (bus.pio_led != 0) on++;
    end
    check("off_cur_period", on, 12);
    count_period(on, seen);
    check("off_next_period", on, 0);
    bus.mode = MODE_BREATH; bus.led_in = 4'b1111;
    rst = 1; clk_step(); rst = 0;
    repeat (16) clk_step();
    for (int p = 1; p <= 64; p++) begin
      check("breath_level", bus.level, tri_lvl((p - 1) / 2));
      lat = int'(bus.level);
      count_period(on, seen);
      check("breath_on_time", on, lat);
    end
    rst = 1; clk_step(); rst = 0;
    repeat (680) clk_step();
    check("ramp_level_down9", bus.level, 9);
    rst = 1; clk_step(); rst = 0;
    check("midramp_rst_level", bus.level, 0);
    check("midramp_rst_pio", bus.pio_led, 0);
    bus.led_in = 4'b0110;
    clk_step();
    check("midramp_rst_passmode", bus.pio_led, 4'b0110);
    repeat (3000) begin
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 7) == 0) bus.led_in = 4'($urandom);
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus.duty = 4'($urandom);
      clk_step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
